// File: rtl/mem_stream_fifo.sv
// Ready/valid stream FIFO between TCDM request/response streams and the bank arbiters.
// Reports fill level and programmable almost-full/almost-empty flags; optional fall-through bypass.
module mem_stream_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned PTR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_ready_o,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    input  logic                  pop_ready_i,
    input  logic [PTR_W:0]        almost_full_thr_i,
    input  logic [PTR_W:0]        almost_empty_thr_i,
    output logic [PTR_W:0]        level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [PTR_W-1:0]      push_ptr_o,
    output logic [PTR_W-1:0]      pop_ptr_o
);

    localparam logic [PTR_W:0] DEPTH_LVL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      push_ptr_q;
    logic [PTR_W-1:0]      pop_ptr_q;
    logic [PTR_W:0]        level_q;
    logic                  empty;
    logic                  full;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  bypass;

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_LVL);

    // Ready depends on registered level only, so a pop never opens a slot in the same cycle.
    assign push_ready_o = !full;

    always_comb begin
        pop_valid_o = !empty;
        pop_data_o  = mem_q[pop_ptr_q];
        if (FALL_THROUGH && empty) begin
            pop_valid_o = push_valid_i;
            pop_data_o  = push_data_i;
        end
    end

    assign push_fire = push_valid_i && push_ready_o;
    assign pop_fire  = pop_valid_o && pop_ready_i;
    // A word that falls straight through never needs to occupy storage.
    assign bypass    = FALL_THROUGH && empty && push_fire && pop_fire;

    always_ff @(posedge clk_i) begin
        if (push_fire && !bypass && !clear_i) begin
            mem_q[push_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
            level_q    <= '0;
        end else if (clear_i) begin
            push_ptr_q <= '0;
            pop_ptr_q  <= '0;
            level_q    <= '0;
        end else begin
            if (push_fire) begin
                push_ptr_q <= push_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                pop_ptr_q <= pop_ptr_q + 1'b1;
            end
            if (push_fire && !pop_fire) begin
                level_q <= level_q + 1'b1;
            end else if (pop_fire && !push_fire) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign level_o        = level_q;
    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_full_o  = (level_q >= almost_full_thr_i);
    assign almost_empty_o = (level_q <= almost_empty_thr_i);
    assign push_ptr_o     = push_ptr_q;
    assign pop_ptr_o      = pop_ptr_q;

endmodule

// File: tb/tb_mem_stream_fifo.sv
// Self-checking bench for mem_stream_fifo: scoreboarded FT=0 instance plus a small FT=1 instance.
module tb_mem_stream_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        pv;
    logic [31:0] pd;
    logic        pr;
    logic [3:0]  thr_af;
    logic [3:0]  thr_ae;

    logic        d0_push_ready, d0_pop_valid, d0_empty, d0_full, d0_af, d0_ae;
    logic [31:0] d0_pop_data;
    logic [3:0]  d0_level;
    logic [2:0]  d0_wptr, d0_rptr;

    logic        f_clear, f_pv, f_pr;
    logic [31:0] f_pd;
    logic        f_push_ready, f_pop_valid, f_empty, f_full, f_af, f_ae;
    logic [31:0] f_pop_data;
    logic [3:0]  f_level;
    logic [2:0]  f_wptr, f_rptr;

    int          n_checks;
    int          n_fail;
    int          m_level;
    logic [2:0]  m_wptr;
    logic [2:0]  m_rptr;
    logic [31:0] sb[$];

    mem_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .push_valid_i(pv), .push_data_i(pd), .push_ready_o(d0_push_ready),
        .pop_valid_o(d0_pop_valid), .pop_data_o(d0_pop_data), .pop_ready_i(pr),
        .almost_full_thr_i(thr_af), .almost_empty_thr_i(thr_ae),
        .level_o(d0_level), .empty_o(d0_empty), .full_o(d0_full),
        .almost_full_o(d0_af), .almost_empty_o(d0_ae),
        .push_ptr_o(d0_wptr), .pop_ptr_o(d0_rptr)
    );

    mem_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(f_clear),
        .push_valid_i(f_pv), .push_data_i(f_pd), .push_ready_o(f_push_ready),
        .pop_valid_o(f_pop_valid), .pop_data_o(f_pop_data), .pop_ready_i(f_pr),
        .almost_full_thr_i(thr_af), .almost_empty_thr_i(thr_ae),
        .level_o(f_level), .empty_o(f_empty), .full_o(f_full),
        .almost_full_o(f_af), .almost_empty_o(f_ae),
        .push_ptr_o(f_wptr), .pop_ptr_o(f_rptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_wptr  = '0;
        m_rptr  = '0;
        sb.delete();
    endtask

    task automatic check_flags();
        check_val("level", 32'(d0_level), 32'(m_level));
        check_val("empty", 32'(d0_empty), 32'(m_level == 0));
        check_val("full", 32'(d0_full), 32'(m_level == DEPTH));
        check_val("push_ready", 32'(d0_push_ready), 32'(m_level != DEPTH));
        check_val("pop_valid", 32'(d0_pop_valid), 32'(m_level != 0));
        check_val("almost_full", 32'(d0_af), 32'(m_level >= int'(thr_af)));
        check_val("almost_empty", 32'(d0_ae), 32'(m_level <= int'(thr_ae)));
        check_val("push_ptr", 32'(d0_wptr), 32'(m_wptr));
        check_val("pop_ptr", 32'(d0_rptr), 32'(m_rptr));
    endtask

    // Called just after a rising edge; drives one cycle, checks before the next edge, updates the model after it.
    task automatic step(input logic pv_i, input logic [31:0] pd_i, input logic pr_i, input logic clr_i);
        logic push_acc;
        logic pop_acc;
        pv    = pv_i;
        pd    = pd_i;
        pr    = pr_i;
        clear = clr_i;
        @(negedge clk);
        check_flags();
        push_acc = pv_i && (m_level < DEPTH);
        pop_acc  = pr_i && (m_level > 0);
        if (pop_acc) begin
            if (sb.size() > 0) check_val("pop_data", d0_pop_data, sb[0]);
            else check_val("scoreboard_nonempty", 32'(sb.size()), 32'd1);
        end
        @(posedge clk);
        #1;
        if (clr_i) begin
            model_reset();
        end else begin
            if (pop_acc) begin
                void'(sb.pop_front());
                m_rptr = m_rptr + 3'd1;
                m_level--;
            end
            if (push_acc) begin
                sb.push_back(pd_i);
                m_wptr = m_wptr + 3'd1;
                m_level++;
            end
        end
        pv    = 1'b0;
        pr    = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        pv       = 1'b0;
        pd       = '0;
        pr       = 1'b0;
        thr_af   = 4'd0;
        thr_ae   = 4'd1;
        f_clear  = 1'b0;
        f_pv     = 1'b0;
        f_pd     = '0;
        f_pr     = 1'b0;
        model_reset();

        #1;
        check_flags();
        check_val("ft_reset_empty", 32'(f_empty), 32'd1);
        check_val("ft_reset_pop_valid", 32'(f_pop_valid), 32'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full; thresholds af=6, ae=1 are checked at every level 0..8.
        thr_af = 4'd6;
        thr_ae = 4'd1;
        for (int i = 0; i < 8; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b0, 1'b0);
        thr_af = 4'd15;
        step(1'b0, '0, 1'b0, 1'b0);
        thr_af = 4'd6;
        // Full with both sides active: only the pop may complete.
        step(1'b1, 32'h99, 1'b1, 1'b0);
        for (int i = 0; i < 8 && m_level > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Steady level 3 with push and pop every cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h40 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Clear at level 5 with a push in flight.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'hEE, 1'b1, 1'b1);
        step(1'b1, 32'h61, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle at level 4.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h70 + 32'(i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_flags();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Fall-through: bypass with consumer ready, then push into empty without pop.
        f_pv = 1'b1;
        f_pd = 32'hAB;
        f_pr = 1'b1;
        @(negedge clk);
        check_val("ft_pop_valid_bypass", 32'(f_pop_valid), 32'd1);
        check_val("ft_pop_data_bypass", f_pop_data, 32'hAB);
        @(posedge clk);
        #1;
        check_val("ft_level_bypass", 32'(f_level), 32'd0);
        check_val("ft_push_ptr_bypass", 32'(f_wptr), 32'd1);
        check_val("ft_pop_ptr_bypass", 32'(f_rptr), 32'd1);
        f_pd = 32'hCD;
        f_pr = 1'b0;
        @(negedge clk);
        check_val("ft_pop_valid_held", 32'(f_pop_valid), 32'd1);
        check_val("ft_pop_data_held", f_pop_data, 32'hCD);
        @(posedge clk);
        #1;
        check_val("ft_level_stored", 32'(f_level), 32'd1);
        check_val("ft_push_ptr_stored", 32'(f_wptr), 32'd2);
        f_pv = 1'b0;
        f_pr = 1'b1;
        @(negedge clk);
        check_val("ft_pop_valid_mem", 32'(f_pop_valid), 32'd1);
        check_val("ft_pop_data_mem", f_pop_data, 32'hCD);
        @(posedge clk);
        #1;
        check_val("ft_level_drained", 32'(f_level), 32'd0);
        check_val("ft_pop_ptr_drained", 32'(f_rptr), 32'd2);
        f_pr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
